// File: rtl/spi_bram_pkg.sv
// Shared definitions for the SPI <-> BRAM link: command bytes, frame geometry and the
// master FSM state encoding.
package spi_bram_pkg;

  localparam logic [7:0]  CMD_WRITE  = 8'h02;
  localparam logic [7:0]  CMD_READ   = 8'h03;
  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned ADDR_W     = 13;
  localparam int unsigned DATA_W     = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI mode-0 clock generator: CLK_DIV cycles low then CLK_DIV cycles high while enabled,
// with strobes flagging the last cycle of each half-period.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o,
  output logic sample_o
);

  localparam int unsigned CntW = $clog2(CLK_DIV + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sclk_q, sclk_d;
  logic            term;

  assign term = (cnt_q == CntW'(CLK_DIV - 1));

  // Disabling parks the clock low with a fresh half-period, so every frame starts aligned.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (term) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o   = sclk_q;
  assign rise_o   = en_i & term & ~sclk_q;
  assign fall_o   = en_i & term & sclk_q;
  assign sample_o = fall_o;

endmodule

// File: rtl/spi_master_bram_client.sv
// SPI master issuing one-byte BRAM read/write frames (cmd | addr | data, MSB first, mode 0)
// to a spi_slave_to_bram peer, one request in flight at a time.
module spi_master_bram_client
  import spi_bram_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_IDLE  = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              sclk_out,
  output logic              mosi_out,
  output logic              cs_out,
  input  logic              miso_in
);

  localparam int unsigned PhaseW = $clog2(max3(CS_SETUP, CS_HOLD, CS_IDLE) + 1);
  localparam int unsigned BitW   = $clog2(FRAME_BITS);

  state_e                  state_q, state_d;
  logic [PhaseW-1:0]       phase_q, phase_d;
  logic [BitW-1:0]         bit_q, bit_d;
  logic                    last_q, last_d;
  logic                    write_q, write_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [DATA_W-1:0]       rx_q, rx_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    sclk_rise, sclk_fall, sclk_sample;

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst),
    .en_i    (state_q == StShift),
    .sclk_o  (sclk_out),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall),
    .sample_o(sclk_sample)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    last_d      = last_q;
    write_d     = write_q;
    frame_d     = frame_q;
    rx_d        = rx_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          frame_d = {req_write ? CMD_WRITE : CMD_READ, {(16 - ADDR_W){1'b0}}, req_addr,
                     req_write ? req_wdata : {DATA_W{1'b0}}};
          write_d = req_write;
          bit_d   = '0;
          last_d  = 1'b0;
          phase_d = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        phase_d = phase_q + PhaseW'(1);
        if (phase_q == PhaseW'(CS_SETUP - 1)) begin
          phase_d = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // Only the final DATA_W captured bits survive, which is exactly the data byte.
        if (sclk_sample) rx_d = {rx_q[DATA_W-2:0], miso_in};
        if (sclk_rise) last_d = (bit_q == BitW'(FRAME_BITS - 1));
        if (sclk_fall) begin
          frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
          if (last_q) state_d = StHold;
          else        bit_d   = bit_q + BitW'(1);
        end
      end
      StHold: begin
        phase_d = phase_q + PhaseW'(1);
        if (phase_q == PhaseW'(CS_HOLD - 1)) begin
          phase_d     = '0;
          state_d     = StGap;
          rsp_valid_d = 1'b1;
          rdata_d     = write_q ? {DATA_W{1'b0}} : rx_q;
        end
      end
      StGap: begin
        phase_d = phase_q + PhaseW'(1);
        if (phase_q == PhaseW'(CS_IDLE - 1)) begin
          phase_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      bit_q       <= '0;
      last_q      <= 1'b0;
      write_q     <= 1'b0;
      frame_q     <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      last_q      <= last_d;
      write_q     <= write_d;
      frame_q     <= frame_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Outputs decode straight from state so an async reset releases the bus instantly.
  assign req_ready = (state_q == StIdle);
  assign busy      = ~req_ready;
  assign cs_out    = (state_q == StIdle) || (state_q == StGap);
  assign mosi_out  = ((state_q == StSetup) || (state_q == StShift)) ? frame_q[FRAME_BITS-1]
                                                                     : 1'b0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_spi_master_bram_client.sv
// Bench: two masters (CLK_DIV=4 and CLK_DIV=1) each talking to a behavioural SPI BRAM slave.
module tb_spi_master_bram_client;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [1:0] req_valid, req_write, miso;
  logic [12:0] req_addr [2];
  logic [7:0]  req_wdata [2];
  wire  [1:0] req_ready, rsp_valid, busy, sclk_out, mosi_out, cs_out;
  wire  [7:0] rsp_rdata [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_master_bram_client #(
      .CLK_DIV((g == 0) ? 4 : 1)
    ) u_dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_write(req_write[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_rdata(rsp_rdata[g]),
      .busy     (busy[g]),
      .sclk_out (sclk_out[g]),
      .mosi_out (mosi_out[g]),
      .cs_out   (cs_out[g]),
      .miso_in  (miso[g])
    );
  end

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Slave / monitor state, sampled on the falling sys_clk edge.
  int rises [2], falls [2], run [2], hrun [2];
  int acc_cnt [2], acc_cyc [2], rsp_cnt [2], lat_cs [2], lat_rdy [2], last_rises [2];
  int hi_min [2] = '{1000, 1000};
  int lo_min [2] = '{1000, 1000};
  int gap_min [2] = '{1000, 1000};
  int hi_max [2], lo_max [2];
  bit had_frame [2];
  logic [31:0] shift [2];
  logic [7:0]  rbyte [2], last_rdata [2];
  bit [1:0] cs_p = 2'b11, sclk_p = 2'b00, rdy_p = 2'b11;
  logic [7:0] mem [2][8192];
  bit         wr [2][8192];
  logic [31:0] fq0 [$], fq1 [$];
  logic [7:0]  ref_mem [int];

  // Initial contents of the remote BRAM; 13'h1FFF holds 8'h5A.
  function automatic logic [7:0] pattern(input logic [12:0] a);
    return 8'h5A ^ ~a[7:0] ^ {3'b000, ~a[12:8]};
  endfunction

  function automatic logic [7:0] bram_rd(input int k, input logic [12:0] a);
    return wr[k][a] ? mem[k][a] : pattern(a);
  endfunction

  always @(negedge sys_clk) begin
    for (int k = 0; k < 2; k++) begin
      if (req_valid[k] && req_ready[k]) begin
        acc_cnt[k] <= acc_cnt[k] + 1;
        acc_cyc[k] <= cyc;
      end
      if (rsp_valid[k]) begin
        rsp_cnt[k]    <= rsp_cnt[k] + 1;
        last_rdata[k] <= rsp_rdata[k];
      end
      if (!cs_out[k]) begin
        if (sclk_out[k] != sclk_p[k]) begin
          if (sclk_out[k]) begin
            shift[k] <= {shift[k][30:0], mosi_out[k]};
            rises[k] <= rises[k] + 1;
            if (rises[k] == 23)
              rbyte[k] <= ({shift[k][22:15]} == 8'h03) ?
                          bram_rd(k, {shift[k][11:0], mosi_out[k]}) : 8'h00;
            if (rises[k] > 0) begin
              if (run[k] < lo_min[k]) lo_min[k] <= run[k];
              if (run[k] > lo_max[k]) lo_max[k] <= run[k];
            end
          end else begin
            falls[k] <= falls[k] + 1;
            if (run[k] < hi_min[k]) hi_min[k] <= run[k];
            if (run[k] > hi_max[k]) hi_max[k] <= run[k];
          end
          run[k] <= 1;
        end else begin
          run[k] <= run[k] + 1;
        end
        if (cs_p[k] && had_frame[k] && hrun[k] < gap_min[k]) gap_min[k] <= hrun[k];
      end else begin
        run[k] <= 0;
        if (!cs_p[k]) begin
          last_rises[k] <= rises[k];
          if (rises[k] == 32) begin
            if (k == 0) fq0.push_back(shift[k]);
            else        fq1.push_back(shift[k]);
            if (shift[k][31:24] == 8'h02) begin
              mem[k][shift[k][20:8]] <= shift[k][7:0];
              wr[k][shift[k][20:8]]  <= 1'b1;
            end
          end
          rises[k]     <= 0;
          falls[k]     <= 0;
          lat_cs[k]    <= cyc - acc_cyc[k] - 1;
          hrun[k]      <= 1;
          had_frame[k] <= 1'b1;
        end else begin
          hrun[k] <= hrun[k] + 1;
        end
      end
      if (req_ready[k] && !rdy_p[k]) lat_rdy[k] <= cyc - acc_cyc[k] - 1;
      cs_p[k]   <= cs_out[k];
      sclk_p[k] <= sclk_out[k];
      rdy_p[k]  <= req_ready[k];
    end
  end

  // Slave shifts out junk during cmd/addr, then the addressed byte MSB first.
  always_comb begin
    miso = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (!cs_out[k]) begin
        if (falls[k] >= 24 && falls[k] < 32) miso[k] = rbyte[k][31 - falls[k]];
        else                                 miso[k] = ~falls[k][0];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_accept(input int k);
    int n;
    n = 0;
    @(negedge sys_clk);
    while (!req_ready[k] && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    check("req_accepted", 32'(req_ready[k]), 32'd1);
  endtask

  task automatic do_req(input int k, input logic w, input logic [12:0] a, input logic [7:0] d);
    tick();
    req_valid[k] = 1'b1;
    req_write[k] = w;
    req_addr[k]  = a;
    req_wdata[k] = d;
    wait_accept(k);
    tick();
    req_valid[k] = 1'b0;
    req_write[k] = 1'($urandom);
    req_addr[k]  = 13'($urandom);
    req_wdata[k] = 8'($urandom);
  endtask

  task automatic wait_rsp(input int k, input int cnt0, input int nrsp);
    int n;
    n = 0;
    while (rsp_cnt[k] < cnt0 + nrsp && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    check("rsp_arrived", 32'(rsp_cnt[k] >= cnt0 + nrsp), 32'd1);
    repeat (10) @(negedge sys_clk);
  endtask

  task automatic check_frame(input int k, input logic [31:0] exp);
    int sz;
    logic [31:0] got;
    sz = (k == 0) ? fq0.size() : fq1.size();
    check("frame_captured", 32'(sz != 0), 32'd1);
    if (sz != 0) begin
      if (k == 0) got = fq0.pop_front();
      else        got = fq1.pop_front();
      check("frame_bits", got, exp);
    end
  endtask

  function automatic logic [31:0] frame_of(input logic w, input logic [12:0] a,
                                           input logic [7:0] d);
    return {w ? 8'h02 : 8'h03, 3'b000, a, w ? d : 8'h00};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, a0, f0, n;
    logic [12:0] ba [3];
    logic [7:0]  bd [3];
    logic [12:0] pool [4];
    logic [12:0] a;
    logic [7:0]  d, exp_rd;
    logic        w;

    sys_rst   = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '{default: '0};
    req_wdata = '{default: '0};
    #1 sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_cs", 32'(cs_out[0]), 32'd1);
    check("rst_sclk", 32'(sclk_out[0]), 32'd0);
    check("rst_mosi", 32'(mosi_out[0]), 32'd0);
    check("rst_ready", 32'(req_ready[0]), 32'd1);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_rdata", 32'(rsp_rdata[0]), 32'd0);
    check("rst_cs_div1", 32'(cs_out[1]), 32'd1);
    tick();
    sys_rst = 1'b1;
    repeat (2) tick();

    // Single write.
    r0 = rsp_cnt[0];
    do_req(0, 1'b1, 13'h00A5, 8'h3C);
    @(negedge sys_clk);
    check("busy_in_flight", 32'(busy[0]), 32'd1);
    check("ready_in_flight", 32'(req_ready[0]), 32'd0);
    check("cs_low_in_flight", 32'(cs_out[0]), 32'd0);
    wait_rsp(0, r0, 1);
    check("write_rsp_once", rsp_cnt[0], r0 + 1);
    check("write_rdata", 32'(last_rdata[0]), 32'h00);
    check_frame(0, 32'h0200A53C);
    check("lat_cs_rise", lat_cs[0], 260);
    check("lat_ready", lat_rdy[0], 262);
    check("sclk_rises", last_rises[0], 32);
    check("sclk_hi_min", hi_min[0], 4);
    check("sclk_hi_max", hi_max[0], 4);
    check("sclk_lo_min", lo_min[0], 4);
    check("sclk_lo_max", lo_max[0], 4);

    // Single read from the top address.
    r0 = rsp_cnt[0];
    do_req(0, 1'b0, 13'h1FFF, 8'hFF);
    wait_rsp(0, r0, 1);
    check_frame(0, 32'h031FFF00);
    check("read_rdata", 32'(last_rdata[0]), 32'h5A);
    check("read_rdata_held", 32'(rsp_rdata[0]), 32'h5A);

    // Three writes with req_valid held high throughout.
    for (int i = 0; i < 3; i++) begin
      ba[i] = 13'($urandom);
      bd[i] = 8'($urandom);
    end
    r0 = rsp_cnt[0];
    a0 = acc_cnt[0];
    tick();
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = ba[0];
    req_wdata[0] = bd[0];
    for (int i = 0; i < 3; i++) begin
      wait_accept(0);
      tick();
      if (i < 2) begin
        req_addr[0]  = ba[i+1];
        req_wdata[0] = bd[i+1];
      end else begin
        req_valid[0] = 1'b0;
      end
    end
    wait_rsp(0, r0, 3);
    repeat (20) @(negedge sys_clk);
    check("b2b_accepts", acc_cnt[0] - a0, 3);
    check("b2b_rsps", rsp_cnt[0] - r0, 3);
    for (int i = 0; i < 3; i++) check_frame(0, frame_of(1'b1, ba[i], bd[i]));
    check("b2b_cs_gap", 32'(gap_min[0] >= 2 && gap_min[0] < 1000), 32'd1);

    // Reset during bit 10 of the shift phase.
    r0 = rsp_cnt[0];
    f0 = fq0.size();
    do_req(0, 1'b1, 13'h0123, 8'h77);
    n = 0;
    while (falls[0] < 10 && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    check("reached_bit10", 32'(falls[0] >= 10), 32'd1);
    tick();
    sys_rst = 1'b0;
    #1;
    check("midrst_cs", 32'(cs_out[0]), 32'd1);
    check("midrst_sclk", 32'(sclk_out[0]), 32'd0);
    check("midrst_mosi", 32'(mosi_out[0]), 32'd0);
    repeat (3) tick();
    sys_rst = 1'b1;
    repeat (300) @(negedge sys_clk);
    check("midrst_no_rsp", rsp_cnt[0], r0);
    check("midrst_no_frame", fq0.size(), f0);
    check("midrst_ready", 32'(req_ready[0]), 32'd1);
    r0 = rsp_cnt[0];
    do_req(0, 1'b0, 13'h0ABC, 8'h11);
    wait_rsp(0, r0, 1);
    check_frame(0, 32'h030ABC00);
    check("post_rst_rdata", 32'(last_rdata[0]), 32'(pattern(13'h0ABC)));

    // CLK_DIV=1 master: write/read pair, then random traffic against a reference BRAM.
    r0 = rsp_cnt[1];
    do_req(1, 1'b1, 13'h0042, 8'hC3);
    wait_rsp(1, r0, 1);
    check_frame(1, 32'h020042C3);
    ref_mem[32'h42] = 8'hC3;
    r0 = rsp_cnt[1];
    do_req(1, 1'b0, 13'h0042, 8'h00);
    wait_rsp(1, r0, 1);
    check_frame(1, 32'h03004200);
    check("div1_readback", 32'(last_rdata[1]), 32'hC3);
    check("div1_lat_cs", lat_cs[1], 68);
    check("div1_lat_ready", lat_rdy[1], 70);

    for (int i = 0; i < 4; i++) pool[i] = 13'($urandom);
    for (int i = 0; i < 20; i++) begin
      a = pool[$urandom_range(0, 3)];
      d = 8'($urandom);
      w = 1'($urandom_range(0, 1));
      if (w)                      exp_rd = 8'h00;
      else if (ref_mem.exists(a)) exp_rd = ref_mem[a];
      else                        exp_rd = pattern(a);
      r0 = rsp_cnt[1];
      do_req(1, w, a, d);
      wait_rsp(1, r0, 1);
      check_frame(1, frame_of(w, a, d));
      check("rand_rdata", 32'(last_rdata[1]), 32'(exp_rd));
      if (w) ref_mem[a] = d;
    end
    check("div1_hi_min", hi_min[1], 1);
    check("div1_hi_max", hi_max[1], 1);
    check("div1_lo_max", lo_max[1], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
